// File: rtl/bta_resp_builder_pkg.sv
// Shared constants for the BTA read-response builder: DSI data types,
// header layout and the response FSM encoding.
package bta_resp_builder_pkg;

  localparam logic [5:0] DT_SET_MAX_RET = 6'h37;
  localparam logic [5:0] DT_DCS_RD      = 6'h06;
  localparam logic [5:0] DT_GEN_RD0     = 6'h04;
  localparam logic [5:0] DT_GEN_RD1     = 6'h14;
  localparam logic [5:0] DT_GEN_RD2     = 6'h24;
  localparam logic [5:0] DT_DCS_SHORT1  = 6'h21;
  localparam logic [5:0] DT_DCS_SHORT2  = 6'h22;
  localparam logic [5:0] DT_GEN_SHORT1  = 6'h11;
  localparam logic [5:0] DT_GEN_SHORT2  = 6'h12;
  localparam logic [5:0] DT_DCS_LONG    = 6'h1C;
  localparam logic [5:0] DT_GEN_LONG    = 6'h1A;

  localparam int HDR_DT_LSB    = 0;
  localparam int HDR_FIELD_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_HDR,
    ST_PUSH
  } state_e;

  function automatic logic is_read_dt(input logic [5:0] dt);
    return dt inside {DT_DCS_RD, DT_GEN_RD0, DT_GEN_RD1, DT_GEN_RD2};
  endfunction

  // ECC byte [31:24] and VC [7:6] stay zero; the controller fills them in.
  function automatic logic [31:0] make_hdr(input logic [5:0] dt, input logic [15:0] field);
    return (32'(dt) << HDR_DT_LSB) | (32'(field) << HDR_FIELD_LSB);
  endfunction

endpackage

// File: rtl/bta_sync_fifo.sv
// Single-clock FIFO with registered (non-show-ahead) read data and a
// synchronous flush that clears the pointers but keeps the last read word.
module bta_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_pop;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level  = wptr - rptr;
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      rdata <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr[AW-1:0]];
      end
    end
  end

  // Caller guarantees push only when not full.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bta_resp_builder.sv
// Decodes DSI read requests, fetches register words and queues the
// response (header then payload) for the bus-turnaround stage.
module bta_resp_builder
  import bta_resp_builder_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int MAX_BYTES = 32,
  parameter int WIDX_W    = 3
) (
  input  logic                     clk_periph,
  input  logic                     rst,
  input  logic [23:0]              mipi_periph_rx_cmd,
  input  logic                     mipi_periph_rx_cmd_valid,
  output logic                     reg_rd_en,
  output logic [7:0]               reg_rd_addr,
  output logic [WIDX_W-1:0]        reg_rd_word,
  input  logic [31:0]              reg_rd_data,
  input  logic                     bta_rd,
  output logic [31:0]              bta_data,
  output logic                     resp_busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err_drop,
  output logic                     err_underflow
);
  logic [5:0]  dt;
  logic [7:0]  d0, d1;
  logic [1:0]  unused_vc;
  logic        cmd_rd, cmd_set, accept;
  logic [15:0] set_n, set_val;

  assign dt        = mipi_periph_rx_cmd[5:0];
  assign unused_vc = mipi_periph_rx_cmd[7:6];
  assign d0        = mipi_periph_rx_cmd[15:8];
  assign d1        = mipi_periph_rx_cmd[23:16];
  assign cmd_rd    = mipi_periph_rx_cmd_valid && is_read_dt(dt);
  assign cmd_set   = mipi_periph_rx_cmd_valid && (dt == DT_SET_MAX_RET);

  assign set_n   = {d1, d0};
  assign set_val = (set_n == 16'd0)              ? 16'd1 :
                   (set_n > 16'(MAX_BYTES))      ? 16'(MAX_BYTES) : set_n;

  state_e            state_q, state_d;
  logic [15:0]       max_ret_q, n_q, n_words;
  logic [7:0]        addr_q;
  logic              dcs_q, short_rsp, last_word;
  logic [WIDX_W-1:0] k_q;
  logic [31:0]       cap_q;

  assign accept    = cmd_rd && (state_q == ST_IDLE);
  assign n_words   = (n_q + 16'd3) >> 2;
  assign short_rsp = (n_q <= 16'd2);
  assign last_word = (16'(k_q) + 16'd1) >= n_words;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RD;
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = (k_q == '0) ? ST_HDR : ST_PUSH;
      ST_HDR:  state_d = short_rsp ? ST_IDLE : ST_PUSH;
      ST_PUSH: state_d = last_word ? ST_IDLE : ST_RD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Short responses carry up to two data bytes inline; long ones carry the count.
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_field;

  always_comb begin
    hdr_dt    = dcs_q ? DT_DCS_LONG : DT_GEN_LONG;
    hdr_field = n_q;
    if (short_rsp) begin
      if (n_q == 16'd1) hdr_dt = dcs_q ? DT_DCS_SHORT1 : DT_GEN_SHORT1;
      else              hdr_dt = dcs_q ? DT_DCS_SHORT2 : DT_GEN_SHORT2;
      hdr_field = {(n_q == 16'd2) ? cap_q[15:8] : 8'h00, cap_q[7:0]};
    end
  end

  logic        fifo_push, fifo_empty, fifo_full;
  logic [31:0] fifo_wdata;

  assign fifo_push  = ((state_q == ST_HDR) || (state_q == ST_PUSH)) && !fifo_full;
  assign fifo_wdata = (state_q == ST_HDR) ? make_hdr(hdr_dt, hdr_field) : cap_q;

  always_ff @(posedge clk_periph) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      max_ret_q     <= 16'd1;
      n_q           <= '0;
      addr_q        <= '0;
      dcs_q         <= 1'b0;
      k_q           <= '0;
      cap_q         <= '0;
      err_drop      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_drop      <= cmd_rd && (state_q != ST_IDLE);
      err_underflow <= bta_rd && fifo_empty;
      if (cmd_set) max_ret_q <= set_val;
      if (accept) begin
        addr_q <= d0;
        dcs_q  <= (dt == DT_DCS_RD);
        n_q    <= max_ret_q;
        k_q    <= '0;
      end
      if (state_q == ST_CAP)  cap_q <= reg_rd_data;
      if (state_q == ST_PUSH) k_q   <= k_q + 1'b1;
    end
  end

  assign reg_rd_en   = (state_q == ST_RD);
  assign reg_rd_addr = addr_q;
  assign reg_rd_word = k_q;
  assign resp_busy   = (state_q != ST_IDLE);

  bta_sync_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk_periph),
    .rst   (rst),
    .flush (accept),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (bta_rd),
    .rdata (bta_data),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_bta_resp_builder.sv
// Directed + randomized bench for bta_resp_builder against a queue-based
// reference of the expected response words.
module tb_bta_resp_builder;
  localparam int DEPTH = 16, MAX_BYTES = 32, WIDX_W = 3;

  logic              clk_periph = 1'b0;
  logic              rst = 1'b1;
  logic [23:0]       cmd = '0;
  logic              cmd_valid = 1'b0;
  logic              reg_rd_en;
  logic [7:0]        reg_rd_addr;
  logic [WIDX_W-1:0] reg_rd_word;
  logic [31:0]       reg_rd_data = '0;
  logic              bta_rd = 1'b0;
  logic [31:0]       bta_data;
  logic              resp_busy;
  logic [4:0]        fifo_level;
  logic              err_drop, err_underflow;

  bta_resp_builder #(.DEPTH(DEPTH), .MAX_BYTES(MAX_BYTES), .WIDX_W(WIDX_W)) dut (
    .clk_periph               (clk_periph),
    .rst                      (rst),
    .mipi_periph_rx_cmd       (cmd),
    .mipi_periph_rx_cmd_valid (cmd_valid),
    .reg_rd_en                (reg_rd_en),
    .reg_rd_addr              (reg_rd_addr),
    .reg_rd_word              (reg_rd_word),
    .reg_rd_data              (reg_rd_data),
    .bta_rd                   (bta_rd),
    .bta_data                 (bta_data),
    .resp_busy                (resp_busy),
    .fifo_level               (fifo_level),
    .err_drop                 (err_drop),
    .err_underflow            (err_underflow)
  );

  always #5 clk_periph = ~clk_periph;

  int          checks = 0, errors = 0;
  logic [31:0] bank [8];
  int          max_ret_m = 1;
  logic [31:0] expq [$];

  // Register bank: data valid the cycle after the strobe, junk otherwise.
  always @(posedge clk_periph) reg_rd_data <= reg_rd_en ? bank[reg_rd_word] : $urandom();

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_periph);
    #1;
  endtask

  task automatic send(input logic [5:0] dt, input logic [7:0] d0, input logic [7:0] d1);
    cmd = {d1, d0, 2'($urandom), dt};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd = 24'($urandom);
  endtask

  function automatic int clamp(input int n);
    if (n == 0) return 1;
    if (n > MAX_BYTES) return MAX_BYTES;
    return n;
  endfunction

  task automatic set_max(input int n);
    logic [15:0] v;
    v = 16'(n);
    send(6'h37, v[7:0], v[15:8]);
    max_ret_m = clamp(n);
  endtask

  function automatic logic [31:0] ref_hdr(input bit dcs, input int n, input logic [31:0] w0);
    int t, fld;
    if (n == 1) begin
      t = dcs ? 'h21 : 'h11;
      fld = int'(w0 % 256);
    end else if (n == 2) begin
      t = dcs ? 'h22 : 'h12;
      fld = int'(w0 % 65536);
    end else begin
      t = dcs ? 'h1C : 'h1A;
      fld = n;
    end
    return 32'(t + fld * 256);
  endfunction

  // mode: 0 plain, 1 read dropped while busy, 2 max-return update while busy,
  //       3 pop the header in the same cycle as the first payload push.
  task automatic do_read(input logic [5:0] dt, input logic [7:0] d0, input int mode, input bit pop_all);
    bit          dcs;
    int          n, nw, c, rd_k, exp_busy, new_max;
    logic [15:0] nv;
    logic [31:0] last;
    dcs = (dt == 6'h06);
    n = max_ret_m;
    nw = (n + 3) / 4;
    rd_k = 0;
    new_max = max_ret_m;
    last = '0;
    expq.delete();
    expq.push_back(ref_hdr(dcs, n, bank[0]));
    if (n > 2) for (int i = 0; i < nw; i++) expq.push_back(bank[i]);
    exp_busy = (n <= 2) ? 4 : 2 + 3 * nw;
    send(dt, d0, 8'($urandom));
    c = 1;
    chk("rd_addr", reg_rd_addr, d0);
    while (resp_busy && c < 200) begin
      if (reg_rd_en) begin
        chk("rd_word", reg_rd_word, rd_k);
        rd_k++;
      end
      if (c == 1) chk("flush_level", fifo_level, 0);
      if (c == 3) chk("pre_hdr_level", fifo_level, 0);
      if (c == 4) chk("hdr_level", fifo_level, 1);
      if (mode == 1) begin
        if (c == 1) begin cmd = {8'h00, 8'h55, 2'b00, 6'h04}; cmd_valid = 1'b1; end
        if (c == 2) begin cmd_valid = 1'b0; chk("drop_pulse", err_drop, 1); end
        if (c == 3) chk("drop_single", err_drop, 0);
      end
      if (mode == 2) begin
        if (c == 1) begin
          nv = 16'($urandom_range(0, 40));
          cmd = {nv[15:8], nv[7:0], 2'b01, 6'h37};
          cmd_valid = 1'b1;
          new_max = clamp(int'(nv));
        end
        if (c == 2) begin cmd_valid = 1'b0; chk("no_drop_on_set", err_drop, 0); end
      end
      if (mode == 3) begin
        if (c == 4) bta_rd = 1'b1;
        if (c == 5) begin
          bta_rd = 1'b0;
          chk("pushpop_level", fifo_level, 1);
          last = expq.pop_front();
          chk("pushpop_data", bta_data, last);
        end
      end
      tick();
      c++;
    end
    max_ret_m = new_max;
    chk("busy_cycles", c, exp_busy);
    chk("resp_level", fifo_level, expq.size());
    if (pop_all) begin
      while (expq.size() > 0) begin
        bta_rd = 1'b1;
        tick();
        bta_rd = 1'b0;
        last = expq.pop_front();
        chk("pop_data", bta_data, last);
        chk("no_underflow", err_underflow, 0);
      end
      chk("drained_level", fifo_level, 0);
      bta_rd = 1'b1;
      tick();
      bta_rd = 1'b0;
      chk("underflow", err_underflow, 1);
      chk("underflow_hold", bta_data, last);
      tick();
      chk("underflow_pulse", err_underflow, 0);
    end
  endtask

  initial begin
    logic [5:0] rd_types [4];
    int         r, n, mode;
    rd_types[0] = 6'h06; rd_types[1] = 6'h04; rd_types[2] = 6'h14; rd_types[3] = 6'h24;
    for (int i = 0; i < 8; i++) bank[i] = $urandom();

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_bta_data", bta_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", resp_busy, 0);
    chk("rst_rd_en", reg_rd_en, 0);
    chk("rst_drop", err_drop, 0);
    chk("rst_underflow", err_underflow, 0);
    rst = 1'b0;
    tick();

    // Default short DCS read, N=1.
    bank[0] = 32'h00000094;
    do_read(6'h06, 8'h0A, 0, 1);
    chk("short_hdr_value", bta_data, 32'h00009421);

    // Long read, N=6.
    set_max(6);
    bank[0] = 32'h44332211;
    bank[1] = 32'h88776655;
    do_read(6'h06, 8'h0A, 0, 1);

    // Clamp to MAX_BYTES, generic.
    for (int i = 0; i < 8; i++) bank[i] = $urandom();
    set_max(16'h0100);
    do_read(6'h14, 8'h33, 0, 1);

    // Drop while busy.
    set_max(6);
    do_read(6'h06, 8'h0B, 1, 1);

    // Stale 2-word response flushed by a new short read.
    set_max(4);
    do_read(6'h04, 8'h10, 0, 0);
    set_max(1);
    do_read(6'h06, 8'h11, 0, 1);

    // Pop coinciding with push.
    set_max(12);
    do_read(6'h24, 8'h12, 3, 1);

    // Max-return update during a response applies to the next one.
    do_read(6'h06, 8'h13, 2, 1);
    do_read(6'h14, 8'h14, 0, 1);

    // Non-read type is ignored.
    send(6'h05, 8'h20, 8'h00);
    chk("ignored_type", resp_busy, 0);

    // Reset during CAP of word 1.
    set_max(6);
    send(6'h06, 8'h0A, 8'h00);
    repeat (5) tick();
    chk("pre_rst_level", fifo_level, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    max_ret_m = 1;
    chk("midrst_level", fifo_level, 0);
    chk("midrst_busy", resp_busy, 0);
    chk("midrst_data", bta_data, 0);
    tick();
    do_read(6'h06, 8'h0C, 0, 1);

    // Randomized requests.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        n = (r == 0) ? 0 : (r == 1) ? $urandom_range(33, 65535) : $urandom_range(1, 32);
        set_max(n);
      end
      for (int i = 0; i < 8; i++) bank[i] = $urandom();
      mode = $urandom_range(0, 3);
      if (mode == 3 && max_ret_m <= 2) mode = 0;
      do_read(rd_types[$urandom_range(0, 3)], 8'($urandom), mode, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
